fsl_link_fifo: RTL

- Synchronous FSL channel FIFO between a MicroBlaze-side FSL master and the test_fsl slave port.
- Directly upstream of test_fsl: drives its FSL_S_Data, FSL_S_Control and FSL_S_Exists, and consumes its FSL_S_Read.
- Buffers 32-bit data words, each with a control flag, in first-word-fall-through order.
- Reports occupancy and sticky overflow/underflow errors.

---
 rtl/fsl_link_fifo.sv | 97 +++++++++
 1 files changed

// File: rtl/fsl_link_fifo.sv
// First-word-fall-through FSL channel FIFO: buffers {control, data} words from
// an FSL master and presents the head entry to the downstream FSL slave.
module fsl_link_fifo #(
  parameter int C_FSL_DWIDTH = 32,
  parameter int C_FSL_DEPTH  = 16,
  parameter int C_FSL_AWIDTH = 4
) (
  input  logic                    FSL_Clk,
  input  logic                    FSL_Rst_n,
  input  logic                    FSL_M_Write,
  input  logic [0:C_FSL_DWIDTH-1] FSL_M_Data,
  input  logic                    FSL_M_Control,
  output logic                    FSL_M_Full,
  input  logic                    FSL_S_Read,
  output logic [0:C_FSL_DWIDTH-1] FSL_S_Data,
  output logic                    FSL_S_Control,
  output logic                    FSL_S_Exists,
  output logic [C_FSL_AWIDTH:0]   FSL_Occupancy,
  output logic                    FSL_Overflow,
  output logic                    FSL_Underflow
);

  // Handshake: a write transfers when FSL_M_Write && !FSL_M_Full at a rising
  // edge; a read transfers when FSL_S_Read && FSL_S_Exists at a rising edge.
  // Strobes outside those conditions are errors and never move data.

  logic [0:C_FSL_DWIDTH-1] mem_data [C_FSL_DEPTH];
  logic                    mem_ctrl [C_FSL_DEPTH];

  logic [C_FSL_AWIDTH-1:0] wr_ptr;
  logic [C_FSL_AWIDTH-1:0] rd_ptr;
  logic [C_FSL_AWIDTH:0]   count;
  logic                    overflow_q;
  logic                    underflow_q;

  logic full;
  logic exists;
  logic wr_acc;
  logic rd_acc;

  assign full   = (count == (C_FSL_AWIDTH+1)'(C_FSL_DEPTH));
  assign exists = (count != '0);
  assign wr_acc = FSL_M_Write && !full;
  assign rd_acc = FSL_S_Read && exists;

  // Storage is deliberately left out of reset; the count gates its visibility.
  always_ff @(posedge FSL_Clk) begin
    if (wr_acc) begin
      mem_data[wr_ptr] <= FSL_M_Data;
      mem_ctrl[wr_ptr] <= FSL_M_Control;
    end
  end

  always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
    if (!FSL_Rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + C_FSL_AWIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + C_FSL_AWIDTH'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + (C_FSL_AWIDTH+1)'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - (C_FSL_AWIDTH+1)'(1);
      end
      if (FSL_M_Write && full) begin
        overflow_q <= 1'b1;
      end
      if (FSL_S_Read && !exists) begin
        underflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    FSL_S_Data    = '0;
    FSL_S_Control = 1'b0;
    if (exists) begin
      FSL_S_Data    = mem_data[rd_ptr];
      FSL_S_Control = mem_ctrl[rd_ptr];
    end
  end

  assign FSL_M_Full    = full;
  assign FSL_S_Exists  = exists;
  assign FSL_Occupancy = count;
  assign FSL_Overflow  = overflow_q;
  assign FSL_Underflow = underflow_q;

endmodule
